mode_sequencer: RTL and testbench

MODE_SEQUENCER -- requirements
Module: mode_sequencer

---
 rtl/mode_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_mode_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_sequencer.sv
// Mode sequencer: receives 16-bit command frames over a slow SPI link from the
// ARM, and applies major/minor mode changes with a driver-quiet window before
// the switch and a settle window after it. Divisor writes apply immediately.
module mode_sequencer #(
  parameter int QUIET_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       ck_1356meg,
  input  logic       nreset,
  input  logic       spck,
  input  logic       mosi,
  input  logic       ncs,
  output logic [2:0] major_mode,
  output logic [4:0] minor_conf,
  output logic [7:0] divisor,
  output logic       drivers_off,
  output logic       busy,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_SWITCH  = 2'd2,
    ST_SETTLE  = 2'd3
  } state_e;

  localparam logic [3:0] OP_CONF    = 4'b0001;
  localparam logic [3:0] OP_DIV     = 4'b0010;
  localparam logic [4:0] FRAME_BITS = 5'd16;

  // Window lengths held one bit wider than the counters so the compare
  // against cnt+1 never wraps, even for a 255-cycle window.
  localparam logic [8:0] QUIET_LIM  = 9'(QUIET_CYCLES);
  localparam logic [8:0] SETTLE_LIM = 9'(SETTLE_CYCLES);

  localparam logic [2:0] RST_MAJOR = 3'b111;
  localparam logic [4:0] RST_MINOR = 5'd0;
  localparam logic [7:0] RST_DIV   = 8'd95;

  // Bit counter increment that sticks at 31 so over-long frames never alias
  // back to a legal length.
  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    if (v == 5'd31) begin
      return 5'd31;
    end else begin
      return v + 5'd1;
    end
  endfunction

  // Counter plus one, widened so it can be compared against a window length.
  function automatic logic [8:0] inc9(input logic [7:0] v);
    return {1'b0, v} + 9'd1;
  endfunction

  // ---------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [1:0] spck_sync_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] ncs_sync_q;
  logic       spck_prev_q;
  logic       ncs_prev_q;

  logic spck_s;
  logic mosi_s;
  logic ncs_s;
  logic spck_rise_s;
  logic ncs_fall_s;
  logic ncs_rise_s;

  assign spck_s = spck_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
  assign ncs_s  = ncs_sync_q[1];

  assign spck_rise_s = spck_s & ~spck_prev_q;
  assign ncs_fall_s  = ~ncs_s & ncs_prev_q;
  assign ncs_rise_s  = ncs_s & ~ncs_prev_q;

  // Two-flop synchronizers plus one history flop each for edge detection;
  // chip select idles high so reset cannot fake a frame boundary.
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      spck_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      ncs_sync_q  <= 2'b11;
      spck_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      spck_sync_q <= {spck_sync_q[0], spck};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      ncs_sync_q  <= {ncs_sync_q[0], ncs};
      spck_prev_q <= spck_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  // ---------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------
  logic [15:0] shift_q;
  logic [15:0] shift_d;
  logic [4:0]  bitcnt_q;
  logic [4:0]  bitcnt_d;

  // Shift in one bit per synchronized SPI clock edge inside a frame; a new
  // frame start clears the length count.
  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    if (ncs_fall_s) begin
      bitcnt_d = 5'd0;
    end else begin
      bitcnt_d = bitcnt_q;
    end
    if (spck_rise_s && !ncs_s) begin
      shift_d  = {shift_q[14:0], mosi_s};
      bitcnt_d = sat_inc5(bitcnt_d);
    end else begin
      shift_d = shift_q;
    end
  end

  // Receiver state registers.
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      shift_q  <= 16'd0;
      bitcnt_q <= 5'd0;
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Command decode (valid only in the frame-end cycle)
  // ---------------------------------------------------------------------
  logic       frame_ok_s;
  logic       div_wr_s;
  logic       conf_wr_s;
  logic [7:0] conf_word_s;

  assign frame_ok_s  = ncs_rise_s && (bitcnt_q == FRAME_BITS);
  assign div_wr_s    = frame_ok_s && (shift_q[15:12] == OP_DIV);
  assign conf_wr_s   = frame_ok_s && (shift_q[15:12] == OP_CONF);
  assign conf_word_s = shift_q[7:0];

  // ---------------------------------------------------------------------
  // Mode transition FSM
  // ---------------------------------------------------------------------
  state_e     state_q;
  state_e     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic [7:0] queue_q;
  logic [7:0] queue_d;
  logic       queue_vld_q;
  logic       queue_vld_d;
  logic [2:0] major_q;
  logic [2:0] major_d;
  logic [4:0] minor_q;
  logic [4:0] minor_d;
  logic [7:0] div_q;
  logic [7:0] div_d;
  logic       drv_off_q;
  logic       drv_off_d;
  logic       busy_q;
  logic       busy_d;
  logic       err_q;
  logic       err_d;

  logic       idle_req_s;
  logic [7:0] idle_word_s;

  // A fresh frame in IDLE takes priority over a queued word; both are newer
  // than anything already applied.
  always_comb begin
    idle_req_s  = conf_wr_s || queue_vld_q;
    idle_word_s = 8'd0;
    if (conf_wr_s) begin
      idle_word_s = conf_word_s;
    end else begin
      idle_word_s = queue_q;
    end
  end

  // Next-state logic for the mode FSM and all registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    queue_d     = queue_q;
    queue_vld_d = queue_vld_q;
    major_d     = major_q;
    minor_d     = minor_q;
    div_d       = div_q;
    err_d       = ncs_rise_s && !(div_wr_s || conf_wr_s);

    if (div_wr_s) begin
      div_d = shift_q[7:0];
    end else begin
      div_d = div_q;
    end

    case (state_q)
      ST_IDLE: begin
        queue_vld_d = 1'b0;
        if (idle_req_s) begin
          if (idle_word_s[7:5] == major_q) begin
            minor_d = idle_word_s[4:0];
          end else begin
            pending_d = idle_word_s;
            state_d   = ST_QUIESCE;
            cnt_d     = 8'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_QUIESCE: begin
        // Last write wins; the quiet window keeps counting.
        if (conf_wr_s) begin
          pending_d = conf_word_s;
        end else begin
          pending_d = pending_q;
        end
        if (inc9(cnt_q) >= QUIET_LIM) begin
          state_d = ST_SWITCH;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SWITCH: begin
        if (conf_wr_s) begin
          queue_d     = conf_word_s;
          queue_vld_d = 1'b1;
        end else begin
          queue_vld_d = queue_vld_q;
        end
        major_d = pending_q[7:5];
        minor_d = pending_q[4:0];
        state_d = ST_SETTLE;
        cnt_d   = 8'd0;
      end
      ST_SETTLE: begin
        if (conf_wr_s) begin
          queue_d     = conf_word_s;
          queue_vld_d = 1'b1;
        end else begin
          queue_vld_d = queue_vld_q;
        end
        if (inc9(cnt_q) >= SETTLE_LIM) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = 8'd0;
        queue_vld_d = 1'b0;
      end
    endcase

    drv_off_d = (state_d == ST_QUIESCE) || (state_d == ST_SWITCH);
    busy_d    = (state_d != ST_IDLE);
  end

  // FSM and output registers; reset drops any transition in flight.
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      pending_q   <= 8'd0;
      queue_q     <= 8'd0;
      queue_vld_q <= 1'b0;
      major_q     <= RST_MAJOR;
      minor_q     <= RST_MINOR;
      div_q       <= RST_DIV;
      drv_off_q   <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      queue_q     <= queue_d;
      queue_vld_q <= queue_vld_d;
      major_q     <= major_d;
      minor_q     <= minor_d;
      div_q       <= div_d;
      drv_off_q   <= drv_off_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign major_mode  = major_q;
  assign minor_conf  = minor_q;
  assign divisor     = div_q;
  assign drivers_off = drv_off_q;
  assign busy        = busy_q;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: one instance with default windows for the basic
// command table, and one with a long quiet window so whole frames fit inside
// QUIESCE for the overwrite, queue and mid-transition reset sequences.
module tb_mode_sequencer;

  logic       clk;
  logic       nreset;
  logic [1:0] spck_v;
  logic [1:0] mosi_v;
  logic [1:0] ncs_v;

  logic [2:0] o_major [2];
  logic [4:0] o_minor [2];
  logic [7:0] o_div   [2];
  logic       o_drv   [2];
  logic       o_busy  [2];
  logic       o_err   [2];

  int checks;
  int errors;
  int cyc;

  mode_sequencer u_dut (
    .ck_1356meg (clk),
    .nreset     (nreset),
    .spck       (spck_v[0]),
    .mosi       (mosi_v[0]),
    .ncs        (ncs_v[0]),
    .major_mode (o_major[0]),
    .minor_conf (o_minor[0]),
    .divisor    (o_div[0]),
    .drivers_off(o_drv[0]),
    .busy       (o_busy[0]),
    .cmd_err    (o_err[0])
  );

  mode_sequencer #(.QUIET_CYCLES(200), .SETTLE_CYCLES(8)) u_dut_long (
    .ck_1356meg (clk),
    .nreset     (nreset),
    .spck       (spck_v[1]),
    .mosi       (mosi_v[1]),
    .ncs        (ncs_v[1]),
    .major_mode (o_major[1]),
    .minor_conf (o_minor[1]),
    .divisor    (o_div[1]),
    .drivers_off(o_drv[1]),
    .busy       (o_busy[1]),
    .cmd_err    (o_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to place frame ends precisely.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Clock out the low nbits of w MSB first; chip select is left low.
  task automatic spi_bits(input int sel, input logic [63:0] w, input int nbits);
    ncs_v[sel] = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi_v[sel] = w[i];
      repeat (2) @(negedge clk);
      spck_v[sel] = 1'b1;
      repeat (4) @(negedge clk);
      spck_v[sel] = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  // Raise chip select and advance to the negedge of cycle F+1.
  task automatic spi_end(input int sel);
    ncs_v[sel]  = 1'b1;
    mosi_v[sel] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input int sel, input logic [2:0] maj,
                         input logic [4:0] mn, input logic [7:0] dv, input logic er,
                         input logic bs, input logic dr);
    chk({tag, "_major"}, 64'(o_major[sel]), 64'(maj));
    chk({tag, "_minor"}, 64'(o_minor[sel]), 64'(mn));
    chk({tag, "_div"},   64'(o_div[sel]),   64'(dv));
    chk({tag, "_err"},   64'(o_err[sel]),   64'(er));
    chk({tag, "_busy"},  64'(o_busy[sel]),  64'(bs));
    chk({tag, "_drv"},   64'(o_drv[sel]),   64'(dr));
  endtask

  // Wait (bounded) while drivers_off is high; returns cycles waited.
  task automatic wait_drv_low(input int sel, output int n);
    n = 0;
    while (o_drv[sel] === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_busy_low(input int sel, output int n);
    n = 0;
    while (o_busy[sel] === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_until(input int target);
    chk("sched_in_time", 64'(cyc <= target), 64'd1);
    while (cyc < target) @(negedge clk);
  endtask

  typedef struct {
    logic [63:0] word;
    int          nbits;
    logic [2:0]  maj;
    logic [4:0]  mn;
    logic [7:0]  dv;
    logic        err;
    logic        busy;
    logic        drv;
    logic [2:0]  s_maj;
    logic [4:0]  s_mn;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n;
    int m;
    int c0;
    int hi;
    checks = 0;
    errors = 0;
    cyc    = 0;

    // word, bits, F+1: major minor div err busy drv, settled: major minor
    vecs[0]  = '{64'h1042,            16, 3'd2, 5'h02, 8'd95,  1'b0, 1'b0, 1'b0, 3'd2, 5'h02};
    vecs[1]  = '{64'h205F,            16, 3'd2, 5'h02, 8'h5F,  1'b0, 1'b0, 1'b0, 3'd2, 5'h02};
    vecs[2]  = '{64'h0ABC,            12, 3'd2, 5'h02, 8'h5F,  1'b1, 1'b0, 1'b0, 3'd2, 5'h02};
    vecs[3]  = '{64'h7123,            16, 3'd2, 5'h02, 8'h5F,  1'b1, 1'b0, 1'b0, 3'd2, 5'h02};
    vecs[4]  = '{64'h1047,            16, 3'd2, 5'h07, 8'h5F,  1'b0, 1'b0, 1'b0, 3'd2, 5'h07};
    vecs[5]  = '{64'h2000,            16, 3'd2, 5'h07, 8'h00,  1'b0, 1'b0, 1'b0, 3'd2, 5'h07};
    vecs[6]  = '{64'h10FF,            16, 3'd2, 5'h07, 8'h00,  1'b0, 1'b1, 1'b1, 3'd7, 5'h1F};
    vecs[7]  = '{64'h10E0,            16, 3'd7, 5'h00, 8'h00,  1'b0, 1'b0, 1'b0, 3'd7, 5'h00};
    vecs[8]  = '{64'h02033,           17, 3'd7, 5'h00, 8'h00,  1'b1, 1'b0, 1'b0, 3'd7, 5'h00};
    vecs[9]  = '{64'hFFFF_FFFF_20AA,  48, 3'd7, 5'h00, 8'h00,  1'b1, 1'b0, 1'b0, 3'd7, 5'h00};
    vecs[10] = '{64'h20AA,            16, 3'd7, 5'h00, 8'hAA,  1'b0, 1'b0, 1'b0, 3'd7, 5'h00};
    vecs[11] = '{64'h0045,            16, 3'd7, 5'h00, 8'hAA,  1'b1, 1'b0, 1'b0, 3'd7, 5'h00};

    nreset = 1'b0;
    spck_v = 2'b00;
    mosi_v = 2'b00;
    ncs_v  = 2'b11;
    repeat (3) @(negedge clk);
    chk_all("rst0", 0, 3'b111, 5'd0, 8'd95, 1'b0, 1'b0, 1'b1);
    chk_all("rst1", 1, 3'b111, 5'd0, 8'd95, 1'b0, 1'b0, 1'b1);
    nreset = 1'b1;
    @(negedge clk);
    chk("rel_drv0", 64'(o_drv[0]), 64'd0);
    chk("rel_drv1", 64'(o_drv[1]), 64'd0);
    repeat (3) @(negedge clk);

    // First mode change with default windows: 16 quiet + 1 switch, 8 settle.
    spi_bits(0, 64'h1045, 16);
    spi_end(0);
    chk_all("m1045_f1", 0, 3'b111, 5'd0, 8'd95, 1'b0, 1'b1, 1'b1);
    wait_drv_low(0, n);
    chk("m1045_drv_len", 64'(n), 64'd17);
    chk("m1045_major", 64'(o_major[0]), 64'd2);
    chk("m1045_minor", 64'(o_minor[0]), 64'h05);
    chk("m1045_busy_settle", 64'(o_busy[0]), 64'd1);
    wait_busy_low(0, m);
    chk("m1045_settle_len", 64'(m), 64'd8);
    repeat (3) @(negedge clk);

    // Command table on the default instance.
    for (int i = 0; i < 12; i++) begin
      spi_bits(0, vecs[i].word, vecs[i].nbits);
      spi_end(0);
      chk_all($sformatf("v%0d_f1", i), 0, vecs[i].maj, vecs[i].mn, vecs[i].dv,
              vecs[i].err, vecs[i].busy, vecs[i].drv);
      @(negedge clk);
      chk($sformatf("v%0d_err_pulse", i), 64'(o_err[0]), 64'd0);
      repeat (28) @(negedge clk);
      chk($sformatf("v%0d_s_major", i), 64'(o_major[0]), 64'(vecs[i].s_maj));
      chk($sformatf("v%0d_s_minor", i), 64'(o_minor[0]), 64'(vecs[i].s_mn));
      chk($sformatf("v%0d_s_busy", i),  64'(o_busy[0]),  64'd0);
      chk($sformatf("v%0d_s_drv", i),   64'(o_drv[0]),   64'd0);
    end

    // Long instance: divisor write during QUIESCE leaves the timing alone.
    spi_bits(1, 64'h1045, 16);
    spi_end(1);
    c0 = cyc;
    chk_all("l1045_f1", 1, 3'b111, 5'd0, 8'd95, 1'b0, 1'b1, 1'b1);
    spi_bits(1, 64'h205F, 16);
    spi_end(1);
    chk_all("ldiv_f1", 1, 3'b111, 5'd0, 8'h5F, 1'b0, 1'b1, 1'b1);
    wait_drv_low(1, n);
    chk("ldiv_drv_len", 64'(cyc - c0), 64'd201);
    wait_busy_low(1, m);
    chk("ldiv_settle_len", 64'(m), 64'd8);
    chk("ldiv_major", 64'(o_major[1]), 64'd2);
    chk("ldiv_minor", 64'(o_minor[1]), 64'h05);

    // Two conf writes inside one quiet window: one transition, last wins.
    repeat (3) @(negedge clk);
    spi_bits(1, 64'h1060, 16);
    spi_end(1);
    c0 = cyc;
    chk("lw_f1_drv", 64'(o_drv[1]), 64'd1);
    spi_bits(1, 64'h10A0, 16);
    spi_end(1);
    chk("lw_f1b_major", 64'(o_major[1]), 64'd2);
    wait_drv_low(1, n);
    chk("lw_drv_len", 64'(cyc - c0), 64'd201);
    wait_busy_low(1, m);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_drv[1] === 1'b1) hi++;
    end
    chk("lw_no_second", 64'(hi), 64'd0);
    chk("lw_major", 64'(o_major[1]), 64'd5);
    chk("lw_minor", 64'(o_minor[1]), 64'h00);

    // Conf write landing in SETTLE is queued and replayed from IDLE.
    spi_bits(1, 64'h1045, 16);
    spi_end(1);
    c0 = cyc;
    spi_bits(1, 64'h1060, 16);
    wait_until(c0 + 200);
    spi_end(1);
    chk_all("q_settle", 1, 3'd2, 5'h05, 8'h5F, 1'b0, 1'b1, 1'b0);
    wait_until(c0 + 209);
    chk("q_idle_busy", 64'(o_busy[1]), 64'd0);
    chk("q_idle_drv",  64'(o_drv[1]),  64'd0);
    @(negedge clk);
    chk("q_replay_drv",  64'(o_drv[1]),  64'd1);
    chk("q_replay_busy", 64'(o_busy[1]), 64'd1);
    chk("q_replay_major", 64'(o_major[1]), 64'd2);
    wait_drv_low(1, n);
    chk("q_replay_len", 64'(n), 64'd201);
    wait_busy_low(1, m);
    chk("q_major", 64'(o_major[1]), 64'd3);
    chk("q_minor", 64'(o_minor[1]), 64'h00);

    // Reset in cycle 5 of QUIESCE aborts the transition.
    repeat (3) @(negedge clk);
    spi_bits(1, 64'h10A5, 16);
    spi_end(1);
    chk("r_f1_drv", 64'(o_drv[1]), 64'd1);
    repeat (4) @(negedge clk);
    nreset = 1'b0;
    #1;
    chk_all("r_abort", 1, 3'b111, 5'd0, 8'd95, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("r_rel_drv", 64'(o_drv[1]), 64'd0);
    hi = 0;
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      if (o_drv[1] === 1'b1 || o_busy[1] === 1'b1) hi++;
    end
    chk("r_no_transition", 64'(hi), 64'd0);
    chk_all("r_final", 1, 3'b111, 5'd0, 8'd95, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
